// File: rtl/gate_lab_pkg.sv
// Shared definitions for the two-input gate lab checkers.
package gate_lab_pkg;

    // Gate function encoding carried on the op inputs
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Checker run states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_DONE  = 2'b10
    } chk_state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational expected-output function for the selected two-input gate.
module gate_ref_model
    import gate_lab_pkg::*;
(
    input  logic [1:0] op,
    input  logic       x,
    input  logic       y,
    output logic       z_exp
);

    // Truth table of the selected gate
    always_comb begin
        z_exp = 1'b0;
        case (op)
            OP_AND:  z_exp = x & y;
            OP_OR:   z_exp = x | y;
            OP_XOR:  z_exp = x ^ y;
            OP_NAND: z_exp = ~(x & y);
            default: z_exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_response_checker.sv
// Response checker: compares observed gate outputs against the reference
// function, counting vectors/mismatches, coverage and the first failure.
module gate_response_checker
    import gate_lab_pkg::*;
#(
    parameter int NUM_VEC = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_x,
    input  logic             s_y,
    input  logic             s_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [1:0]       first_err_xy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

    chk_state_e state_q, state_d;
    logic [1:0] op_q;
    logic       z_exp;
    logic       xfer;
    logic       start_run;
    logic [1:0] xy;

    gate_ref_model u_ref (
        .op    (op_q),
        .x     (s_x),
        .y     (s_y),
        .z_exp (z_exp)
    );

    assign xy        = {s_x, s_y};
    assign s_ready   = (state_q == ST_CHECK);
    assign busy      = (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign xfer      = s_valid && s_ready;
    assign start_run = start && (state_q != ST_CHECK);
    assign pass      = done && (err_cnt == '0) && (cov == 4'b1111);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start launches a run, the NUM_VEC-th transfer ends it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: if (xfer && (vec_cnt == LAST_IDX)) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Op latch, counters, coverage and first-failure capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= OP_AND;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            cov           <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_xy  <= '0;
        end else if (start_run) begin
            op_q          <= op;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            cov           <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_xy  <= '0;
        end else if (xfer) begin
            vec_cnt  <= vec_cnt + 1'b1;
            cov[xy]  <= 1'b1;
            if (s_z != z_exp) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (!first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= vec_cnt;
                    first_err_xy  <= xy;
                end
            end
        end
    end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Sequential response checker for the two-input logic-gate labs: the observing end of a gate test, consuming (x, y, z) samples produced by a stimulus source around a gate under test. Computes the expected output for a selected gate function, counts vectors and mismatches, tracks input-combination coverage and records the first failure. Sits beside the gate under test, driven by a pattern source over a valid/ready handshake.

## Interface
- NUM_VEC, 8: vectors checked per run; 1..2^CNT_W-1.
- CNT_W, 8: width of vector/error counters.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- op  in  2  gate function, latched on start: 00 AND, 01 OR, 10 XOR, 11 NAND.
- s_valid  in  1  sample valid.
- s_ready  out  1  checker accepts a sample.
- s_x, s_y  in  1 each  gate inputs applied.
- s_z  in  1  gate output observed.
- busy  out  1  run in progress (CHECK).
- done  out  1  run complete (DONE).
- pass  out  1  valid in DONE: err_cnt==0 and cov==4'b1111.
- vec_cnt  out  CNT_W  samples accepted this run.
- err_cnt  out  CNT_W  mismatches this run, saturating at all-ones.
- cov  out  4  bit {x,y} set once that combination has been accepted.
- first_err_vld  out  1  at least one mismatch recorded.
- first_err_idx  out  CNT_W  vec_cnt value at first mismatch (0-based).
- first_err_xy  out  2  {x,y} of first mismatch.

## Operation
- States: IDLE, CHECK, DONE.
- IDLE: s_ready=0. start=1 -> CHECK; latch op; clear vec_cnt, err_cnt, cov, first_err_*.
- CHECK: s_ready=1. Transfer occurs when s_valid&&s_ready.
- Per transfer: exp = f(op_latched, s_x, s_y); vec_cnt+1; cov[{s_x,s_y}] set; if s_z!=exp then err_cnt+1 (saturating) and, if first_err_vld=0, capture idx/xy and set first_err_vld.
- The transfer that makes vec_cnt reach NUM_VEC moves the state to DONE.
- DONE: s_ready=0; all results held stable. start=1 -> CHECK with the same clear and latch as from IDLE.
- start in CHECK is ignored. op changes outside the start cycle have no effect.
- s_x/s_y/s_z are don't-care when no transfer occurs; samples with s_valid=1 in IDLE/DONE are not consumed.
- pass=0 outside DONE.

## Timing
- rst: state IDLE. s_ready, busy, done, pass, first_err_vld = 0; vec_cnt, err_cnt, first_err_idx = 0; cov = 4'b0000; first_err_xy = 2'b00; latched op = 00.
- rst overrides all other inputs, including mid-run. The run is discarded and the block returns to IDLE.
- s_ready, busy and done decode the registered state only, with no combinational path from inputs.
- start at edge t: busy=1 and s_ready=1 from t+1.
- Transfer at edge t: counters, cov and first_err_* are updated at t+1.
- Throughput: one sample per cycle.
- Final transfer at edge t: done=1, busy=0, s_ready=0 and pass valid, all at t+1.
- Minimum run length is NUM_VEC+1 cycles from start to done.

## Structure
- Shared package gate_lab_pkg: op encoding constants (OP_AND, OP_OR, OP_XOR, OP_NAND) and the state enum.
- One sub-module, gate_ref_model: purely combinational expected-output function (op, x, y -> exp). It is reused by other lab checkers.
- Checker FSM, counters and capture registers live in the top module.

## Test plan
- OR, 8 vectors cycling {00,01,10,11} with z correct and s_valid held high -> done 8 cycles after the first transfer, vec_cnt=8, err_cnt=0, cov=1111, pass=1.
- AND, vectors 00,01,10,11,11,10,01,00, with vector 2 (x=1,y=0) driven z=1 -> err_cnt=1, first_err_idx=2, first_err_xy=10, pass=0.
- XOR, 8 correct vectors all using x=y=0 -> err_cnt=0, cov=0001, pass=0.
- NAND, s_valid toggled every other cycle -> only valid cycles counted; done after 8 transfers (about 16 cycles); pulsing start at cycle 3 of the run has no effect.
- rst asserted after 4 transfers -> all outputs return to reset values next cycle. A new start then restarts with vec_cnt=0.
- NUM_VEC=255, CNT_W=8, every z wrong -> err_cnt=255 with no wrap, first_err_idx=0, done after 255 transfers. A start in DONE clears everything and runs again.
